fft_mag_reader: RTL and testbench

- Downstream stage of fft_pipeline. Starts when fft_done rises and walks the result RAM through addr_rd, bins 0..N-1.
- Takes o_real/o_img back in, computes approximate magnitude |X| ≈ max + 3·min/8, and streams bins out with valid/ready.
- Replaces the software sqrt(re²+im²) readback in hardware; feeds the spectrum/display logic.

---
 rtl/fft_mag_reader_pkg.sv | 17 +
 rtl/fft_mag_reader_if.sv | 44 ++++
 rtl/fft_mag_approx.sv | 48 ++++
 rtl/fft_mag_reader.sv | 172 +++++++++++++++++
 tb/tb_fft_mag_reader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_mag_reader_pkg.sv
// fft_mag_reader_pkg
//   Shared definitions for the FFT magnitude readback path.
//   - state_t        : reader sequencing states
//   - BETA_NUM_SHIFT : 3*min is built as min + (min << BETA_NUM_SHIFT)
//   - BETA_SHIFT     : the 3*min term is divided by 2^BETA_SHIFT (i.e. /8)
package fft_mag_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BETA_NUM_SHIFT = 1;
    localparam int BETA_SHIFT     = 3;

endpackage

// File: rtl/fft_mag_reader_if.sv
// fft_mag_reader_if
//   Bundles the result-RAM read port and the magnitude output stream.
//   RAM side   : addr_rd (reader -> fft_pipeline), o_real/o_img (registered
//                read data, valid one clk after addr_rd)
//   Stream side: mag_valid/mag_ready handshake with mag_data, mag_index,
//                mag_last (high with bin N-1)
//   modport master : the reader (fft_mag_reader)
//   modport slave  : the environment (RAM + downstream consumer)
interface fft_mag_reader_if #(
    parameter int ADDR_WIDTH     = 10,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int MAG_WIDTH      = OUT_DATA_WIDTH + 1
);
    logic        [ADDR_WIDTH-1:0]     addr_rd;
    logic signed [OUT_DATA_WIDTH-1:0] o_real;
    logic signed [OUT_DATA_WIDTH-1:0] o_img;
    logic                             mag_valid;
    logic                             mag_ready;
    logic        [MAG_WIDTH-1:0]      mag_data;
    logic        [ADDR_WIDTH-1:0]     mag_index;
    logic                             mag_last;

    modport master (
        output addr_rd,
        input  o_real,
        input  o_img,
        output mag_valid,
        input  mag_ready,
        output mag_data,
        output mag_index,
        output mag_last
    );

    modport slave (
        input  addr_rd,
        output o_real,
        output o_img,
        input  mag_valid,
        output mag_ready,
        input  mag_data,
        input  mag_index,
        input  mag_last
    );
endinterface

// File: rtl/fft_mag_approx.sv
// fft_mag_approx
//   Registered approximate complex magnitude: |X| ~= max + 3*min/8,
//   with max/min taken over |re| and |im|. The register loads only when
//   en is high, so it can sit directly in a stallable pipeline.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset (mag -> 0)
//     en         : load enable
//     re, im     : signed W-bit inputs
//     mag        : unsigned MAG_WIDTH-bit registered magnitude
module fft_mag_approx
    import fft_mag_reader_pkg::*;
#(
    parameter int W         = 16,
    parameter int MAG_WIDTH = W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [W-1:0]  re,
    input  logic signed [W-1:0]  im,
    output logic [MAG_WIDTH-1:0] mag
);

    localparam int SW = MAG_WIDTH + 2;

    logic [W-1:0]  abs_re;
    logic [W-1:0]  abs_im;
    logic [W-1:0]  mx;
    logic [W-1:0]  mn;
    logic [SW-1:0] sum;

    // Unsigned W-bit result, so the most negative input maps to 2^(W-1).
    assign abs_re = re[W-1] ? (~$unsigned(re) + 1'b1) : $unsigned(re);
    assign abs_im = im[W-1] ? (~$unsigned(im) + 1'b1) : $unsigned(im);

    assign mx  = (abs_re > abs_im) ? abs_re : abs_im;
    assign mn  = (abs_re > abs_im) ? abs_im : abs_re;
    assign sum = SW'(mx) + ((SW'(mn) + (SW'(mn) << BETA_NUM_SHIFT)) >> BETA_SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag <= '0;
        end else if (en) begin
            mag <= MAG_WIDTH'(sum);
        end
    end

endmodule

// File: rtl/fft_mag_reader.sv
// fft_mag_reader
//   Walks the fft_pipeline result RAM (bins 0..N-1) after each rising edge
//   of fft_done and streams approximate bin magnitudes with valid/ready.
//   Pipeline: address issue -> RAM read tag -> data capture -> magnitude.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     fft_done   : frame trigger level, rising edge starts a frame
//     bus        : fft_mag_reader_if.master (RAM read port + output stream)
//     busy       : frame in progress
//     overrun    : sticky, fft_done rose while busy (cleared by reset only)
//     peak_mag, peak_index : largest magnitude of the frame and its lowest
//                  bin, present only when FFT_MAG_PEAK_EN is defined
//   Macro: FFT_MAG_PEAK_EN enables the peak tracker.
module fft_mag_reader
    import fft_mag_reader_pkg::*;
#(
    parameter int N              = 1024,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH     = $clog2(N),
    parameter int MAG_WIDTH      = OUT_DATA_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fft_done,
    fft_mag_reader_if.master      bus,
    output logic                  busy,
    output logic                  overrun
`ifdef FFT_MAG_PEAK_EN
    ,
    output logic [MAG_WIDTH-1:0]  peak_mag,
    output logic [ADDR_WIDTH-1:0] peak_index
`endif
);

    // state    | meaning
    // ST_IDLE  | waiting for a fft_done rising edge
    // ST_READ  | issuing addresses 0..N-1, one per advancing clk
    // ST_DRAIN | address wrapped, waiting for bin N-1 to be accepted

    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(N - 1);

    state_t                           state, state_nx;
    logic                             fft_done_q;
    logic                             done_rise;
    logic                             start;
    logic                             advance;
    logic                             accept;
    logic                             iss_v;
    logic        [ADDR_WIDTH-1:0]     addr_q;
    logic                             rd_v;
    logic        [ADDR_WIDTH-1:0]     rd_idx;
    logic                             cap_v;
    logic        [ADDR_WIDTH-1:0]     cap_idx;
    logic signed [OUT_DATA_WIDTH-1:0] cap_re, cap_im;
    logic                             adv_q;
    logic signed [OUT_DATA_WIDTH-1:0] skid_re, skid_im;
    logic                             out_v;
    logic        [ADDR_WIDTH-1:0]     out_idx;
    logic                             last_w;
    logic        [MAG_WIDTH-1:0]      mag;

    assign done_rise = fft_done & ~fft_done_q;
    assign advance   = ~out_v | bus.mag_ready;
    assign accept    = out_v & bus.mag_ready;
    assign iss_v     = (state == ST_READ);
    assign last_w    = out_v & (out_idx == LAST_BIN);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (done_rise) begin
                    state_nx = ST_READ;
                    start    = 1'b1;
                end
            end
            ST_READ: begin
                if (advance && (addr_q == LAST_BIN)) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (accept && last_w) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            fft_done_q <= 1'b0;
            overrun    <= 1'b0;
            addr_q     <= '0;
            rd_v       <= 1'b0;
            rd_idx     <= '0;
            cap_v      <= 1'b0;
            cap_idx    <= '0;
            cap_re     <= '0;
            cap_im     <= '0;
            adv_q      <= 1'b0;
            skid_re    <= '0;
            skid_im    <= '0;
            out_v      <= 1'b0;
            out_idx    <= '0;
        end else begin
            state      <= state_nx;
            fft_done_q <= fft_done;
            if (done_rise && (state != ST_IDLE)) overrun <= 1'b1;

            // RAM data on the bus belongs to rd_idx only in the clk right
            // after an advance; later stall clks show data for the held
            // addr_rd, so the first stall clk's data is kept in the skid.
            adv_q <= advance;
            if (adv_q) begin
                skid_re <= bus.o_real;
                skid_im <= bus.o_img;
            end

            if (start) begin
                addr_q <= '0;
            end else if (advance && iss_v) begin
                addr_q <= addr_q + 1'b1;  // N is a power of two: wraps to 0
            end

            if (advance) begin
                rd_v    <= iss_v;
                rd_idx  <= addr_q;
                cap_v   <= rd_v;
                cap_idx <= rd_idx;
                cap_re  <= adv_q ? bus.o_real : skid_re;
                cap_im  <= adv_q ? bus.o_img  : skid_im;
                out_v   <= cap_v;
                out_idx <= cap_idx;
            end
        end
    end

    fft_mag_approx #(
        .W         (OUT_DATA_WIDTH),
        .MAG_WIDTH (MAG_WIDTH)
    ) u_approx (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .re    (cap_re),
        .im    (cap_im),
        .mag   (mag)
    );

    assign bus.addr_rd   = addr_q;
    assign bus.mag_valid = out_v;
    assign bus.mag_data  = mag;
    assign bus.mag_index = out_idx;
    assign bus.mag_last  = last_w;

`ifdef FFT_MAG_PEAK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_mag   <= '0;
            peak_index <= '0;
        end else if (start) begin
            peak_mag   <= '0;
            peak_index <= '0;
        end else if (accept && (mag > peak_mag)) begin
            peak_mag   <= mag;
            peak_index <= out_idx;
        end
    end
`endif

endmodule

// File: tb/tb_fft_mag_reader.sv
// tb_fft_mag_reader
//   Bench for fft_mag_reader with two instances (N=8 and N=1024) sharing
//   clk/reset. Each has a registered-read RAM model driven from int arrays.
//   Peak checks are compiled in when FFT_MAG_PEAK_EN is defined.
module tb_fft_mag_reader;
    localparam int W = 16;

    typedef struct {
        int re;
        int im;
        int mag;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic fd8, fdk, rdy;
    logic busy8, busyk, ovr8, ovrk;
    bit   sel;

    always #5 clk = ~clk;

    fft_mag_reader_if #(.ADDR_WIDTH(3),  .OUT_DATA_WIDTH(W), .MAG_WIDTH(W+1)) b8 ();
    fft_mag_reader_if #(.ADDR_WIDTH(10), .OUT_DATA_WIDTH(W), .MAG_WIDTH(W+1)) bk ();

`ifdef FFT_MAG_PEAK_EN
    logic [W:0] pk8_mag, pkk_mag;
    logic [2:0] pk8_idx;
    logic [9:0] pkk_idx;
`endif

    fft_mag_reader #(.N(8), .OUT_DATA_WIDTH(W)) u8 (
        .clk(clk), .reset(reset), .fft_done(fd8), .bus(b8),
        .busy(busy8), .overrun(ovr8)
`ifdef FFT_MAG_PEAK_EN
        , .peak_mag(pk8_mag), .peak_index(pk8_idx)
`endif
    );

    fft_mag_reader #(.N(1024), .OUT_DATA_WIDTH(W)) uk (
        .clk(clk), .reset(reset), .fft_done(fdk), .bus(bk),
        .busy(busyk), .overrun(ovrk)
`ifdef FFT_MAG_PEAK_EN
        , .peak_mag(pkk_mag), .peak_index(pkk_idx)
`endif
    );

    int ram8_re[8], ram8_im[8];
    int ramk_re[1024], ramk_im[1024];
    int expv[1024];

    assign b8.mag_ready = rdy;
    assign bk.mag_ready = rdy;

    always @(posedge clk) begin
        b8.o_real <= W'(ram8_re[b8.addr_rd]);
        b8.o_img  <= W'(ram8_im[b8.addr_rd]);
        bk.o_real <= W'(ramk_re[bk.addr_rd]);
        bk.o_img  <= W'(ramk_im[bk.addr_rd]);
    end

    // Observed stream of the instance under test.
    logic mv;
    int   md, mi, ml, bsy, ovr, ma;
    always_comb begin
        mv  = b8.mag_valid;
        md  = int'(b8.mag_data);
        mi  = int'(b8.mag_index);
        ml  = int'(b8.mag_last);
        bsy = int'(busy8);
        ovr = int'(ovr8);
        ma  = int'(b8.addr_rd);
        if (sel) begin
            mv  = bk.mag_valid;
            md  = int'(bk.mag_data);
            mi  = int'(bk.mag_index);
            ml  = int'(bk.mag_last);
            bsy = int'(busyk);
            ovr = int'(ovrk);
            ma  = int'(bk.addr_rd);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_mag(input int re, input int im);
        int a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + (3 * mn) / 8;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Trigger one frame on the selected instance and check every accepted
    // bin against expv[]. glitch_at>0 raises fft_done again once that many
    // bins have been accepted (and leaves it high).
    task automatic run_frame(input string tag, input int n, input int rdy_pct,
                             input int glitch_at);
        int   got, cyc, first_v, pd, pi, pl;
        logic pv, pr, r;
        got = 0; cyc = 0; first_v = -1; pd = 0; pi = 0; pl = 0;
        pv = 1'b0; pr = 1'b1;
        @(negedge clk);
        if (sel) fdk = 1'b1; else fd8 = 1'b1;
        rdy = 1'b1;
        while (got < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                fd8 = 1'b0;
                fdk = 1'b0;
            end
            if (mv && first_v < 0) first_v = cyc;
            if (pv && !pr) begin
                check({tag, " hold valid"}, int'(mv), 1);
                check({tag, " hold data"},  md, pd);
                check({tag, " hold index"}, mi, pi);
                check({tag, " hold last"},  ml, pl);
            end
            r   = ($urandom_range(99) < rdy_pct);
            rdy = r;
            if (mv && r) begin
                check({tag, " index"}, mi, got);
                check({tag, " data"},  md, expv[got]);
                check({tag, " last"},  ml, (got == n - 1) ? 1 : 0);
                got++;
                if (got == glitch_at) begin
                    if (sel) fdk = 1'b1; else fd8 = 1'b1;
                end
            end
            pv = mv; pd = md; pi = mi; pl = ml; pr = r;
        end
        check({tag, " bins accepted"}, got, n);
        check({tag, " first valid clk"}, first_v, 4);
        @(negedge clk);
        check({tag, " busy after"},  bsy, 0);
        check({tag, " valid after"}, int'(mv), 0);
        rdy = 1'b1;
    endtask

    vec_t tbl[8];

    initial begin
        int  cyc;
        bit  found;
        sel = 1'b0; fd8 = 1'b0; fdk = 1'b0; rdy = 1'b1; reset = 1'b1;

        tbl[0] = '{-32768,      0, 32768};
        tbl[1] = '{  1000,   1000,  1375};
        tbl[2] = '{     0,      0,     0};
        tbl[3] = '{    -7,      2,     7};
        tbl[4] = '{     3,     -4,     5};
        tbl[5] = '{ 32767, -32768, 45055};
        tbl[6] = '{    -1,     -1,     1};
        tbl[7] = '{-32768, -32768, 45056};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset addr_rd",   ma, 0);
        check("reset mag_valid", int'(mv), 0);
        check("reset mag_data",  md, 0);
        check("reset mag_index", mi, 0);
        check("reset mag_last",  ml, 0);
        check("reset busy",      bsy, 0);
        check("reset overrun",   ovr, 0);
        check("reset busy 1k",   int'(busyk), 0);

        // Basic frame: every bin (3,-4).
        for (int i = 0; i < 8; i++) begin
            ram8_re[i] = 3; ram8_im[i] = -4; expv[i] = 5;
        end
        run_frame("basic", 8, 100, 0);
        check("basic overrun", ovr, 0);

        // Table vectors, one per bin.
        for (int i = 0; i < 8; i++) begin
            ram8_re[i] = tbl[i].re;
            ram8_im[i] = tbl[i].im;
            expv[i]    = tbl[i].mag;
        end
        run_frame("table", 8, 100, 0);

        // Random data with random backpressure on the small instance.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                ram8_re[i] = rnd16(); ram8_im[i] = rnd16();
                expv[i] = ref_mag(ram8_re[i], ram8_im[i]);
            end
            run_frame("rand8", 8, 50, 0);
        end

        // Second rising edge at bin 5: ignored, overrun sticks.
        run_frame("overrun frame", 8, 100, 5);
        check("overrun set", ovr, 1);
        repeat (5) @(negedge clk);
        check("held high no retrigger", bsy, 0);
        fd8 = 1'b0;
        @(negedge clk);
        run_frame("after overrun", 8, 100, 0);
        check("overrun sticky", ovr, 1);

        // Asynchronous reset while bin 3 is on the output.
        found = 1'b0;
        @(negedge clk);
        fd8 = 1'b1;
        cyc = 0;
        while (!found && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) fd8 = 1'b0;
            if (mv && mi == 3) found = 1'b1;
        end
        check("reached bin 3", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("async rst mag_valid", int'(mv), 0);
        check("async rst mag_data",  md, 0);
        check("async rst mag_index", mi, 0);
        check("async rst mag_last",  ml, 0);
        check("async rst addr_rd",   ma, 0);
        check("async rst busy",      bsy, 0);
        check("async rst overrun",   ovr, 0);
        @(negedge clk);
        reset = 1'b0;
        run_frame("post reset", 8, 100, 0);

        // Full N=1024 frame, random data, 50% ready.
        sel = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            ramk_re[i] = rnd16(); ramk_im[i] = rnd16();
        end
        ramk_re[0] = -32768; ramk_im[0] = 0;
        ramk_re[1023] = -32768; ramk_im[1023] = -32768;
        for (int i = 0; i < 1024; i++) expv[i] = ref_mag(ramk_re[i], ramk_im[i]);
        run_frame("frame1k", 1024, 50, 0);
        check("frame1k overrun", ovr, 0);
        sel = 1'b0;

`ifdef FFT_MAG_PEAK_EN
        // Bins 2 and 6 tie at 500; the lower index must win.
        for (int i = 0; i < 8; i++) begin
            ram8_re[i] = 100 + 30 * i; ram8_im[i] = 0;
        end
        ram8_re[2] = 500; ram8_im[2] = 0;
        ram8_re[6] = 0;   ram8_im[6] = -500;
        for (int i = 0; i < 8; i++) expv[i] = ref_mag(ram8_re[i], ram8_im[i]);
        run_frame("peak", 8, 50, 0);
        check("peak_mag",   int'(pk8_mag), 500);
        check("peak_index", int'(pk8_idx), 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
